// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - round-robin I/D arbiter for a shared single-port unified memory
module unified_mem_arbiter #(
   parameter int MEM_WORDS = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         i_req_valid,
   input  logic [31:0]                  i_addr,
   output logic                         i_req_ready,
   output logic                         i_rsp_valid,
   output logic [31:0]                  i_rdata,
   input  logic                         d_req_valid,
   input  logic [31:0]                  d_addr,
   input  logic                         d_we,
   input  logic [3:0]                   d_be,
   input  logic [31:0]                  d_wdata,
   output logic                         d_req_ready,
   output logic                         d_rsp_valid,
   output logic [31:0]                  d_rdata,
   output logic                         mem_en,
   output logic [3:0]                   mem_we,
   output logic [$clog2(MEM_WORDS)-1:0] mem_addr,
   output logic [31:0]                  mem_wdata,
   input  logic [31:0]                  mem_rdata
);

   localparam int AW = $clog2(MEM_WORDS);
   // A byte address is in range exactly when it lies below the first byte past the last word.
   localparam logic [31:0] BYTE_LIMIT = 32'(MEM_WORDS * 4);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic        owner_d_q, owner_d_d;   // 1: the in-flight access belongs to D
   logic        zero_q, zero_d;         // response data must read as 0 (store or out of range)
   logic        last_d_q, last_d_d;     // 1: D was served most recently

   logic        i_win, d_win;
   logic        accept_i, accept_d, accept;
   logic [31:0] sel_addr;
   logic        in_range;

   // Round-robin winner and accept decision; nothing is accepted in RESP or under reset
   always_comb begin
      i_win    = i_req_valid & (~d_req_valid | last_d_q);
      d_win    = d_req_valid & (~i_req_valid | ~last_d_q);
      accept_i = rst_n & (state_q == ST_IDLE) & i_win;
      accept_d = rst_n & (state_q == ST_IDLE) & d_win;
      accept   = accept_i | accept_d;
      sel_addr = accept_d ? d_addr : i_addr;
      in_range = (sel_addr < BYTE_LIMIT);
   end

   // Next-state, response bookkeeping and every output of the block
   always_comb begin
      state_d     = state_q;
      owner_d_d   = owner_d_q;
      zero_d      = zero_q;
      last_d_d    = last_d_q;
      i_req_ready = accept_i;
      d_req_ready = accept_d;
      i_rsp_valid = 1'b0;
      d_rsp_valid = 1'b0;
      i_rdata     = 32'h0;
      d_rdata     = 32'h0;
      mem_en      = 1'b0;
      mem_we      = 4'h0;
      mem_addr    = '0;
      mem_wdata   = 32'h0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               mem_addr  = sel_addr[AW+1:2];
               mem_wdata = d_wdata;
               mem_en    = in_range;
               if (accept_d && d_we && in_range) begin
                  mem_we = d_be;
               end
               state_d   = ST_RESP;
               owner_d_d = accept_d;
               zero_d    = ~in_range | (accept_d & d_we);
               last_d_d  = accept_d;
            end
         end
         ST_RESP: begin
            i_rsp_valid = ~owner_d_q;
            d_rsp_valid = owner_d_q;
            if (!zero_q) begin
               if (owner_d_q) begin
                  d_rdata = mem_rdata;
               end else begin
                  i_rdata = mem_rdata;
               end
            end
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State register; reset abandons any in-flight access and hands the first tie to I
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         owner_d_q <= 1'b0;
         zero_q    <= 1'b0;
         last_d_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         owner_d_q <= owner_d_d;
         zero_q    <= zero_d;
         last_d_q  <= last_d_d;
      end
   end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

   localparam int MW = 256;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req_valid, i_req_ready, i_rsp_valid;
   logic [31:0] i_addr, i_rdata;
   logic        d_req_valid, d_we, d_req_ready, d_rsp_valid;
   logic [3:0]  d_be;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        mem_en;
   logic [3:0]  mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata, mem_rdata;

   logic [31:0] env_mem [0:MW-1];
   logic [31:0] ref_mem [0:MW-1];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   unified_mem_arbiter #(.MEM_WORDS(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_req_valid(i_req_valid), .i_addr(i_addr), .i_req_ready(i_req_ready),
      .i_rsp_valid(i_rsp_valid), .i_rdata(i_rdata),
      .d_req_valid(d_req_valid), .d_addr(d_addr), .d_we(d_we), .d_be(d_be),
      .d_wdata(d_wdata), .d_req_ready(d_req_ready), .d_rsp_valid(d_rsp_valid),
      .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   // Single-port memory with one-cycle read latency; garbage on idle cycles
   always @(posedge clk) begin
      if (mem_en) begin
         mem_rdata <= env_mem[mem_addr];
         for (int b = 0; b < 4; b++)
            if (mem_we[b]) env_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
         mem_rdata <= $urandom;
      end
   end

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++)
         if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
      return r;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      if ($urandom_range(0, 7) == 0)
         a = $urandom_range(0, 1) ? ($urandom | 32'h8000_0000) : (32'h400 + ($urandom & 32'hFFFF));
      else
         a = ($urandom_range(0, MW - 1) * 4) + $urandom_range(0, 3);
      return a;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req_valid = 1'b0; i_addr = 32'h0;
      d_req_valid = 1'b0; d_addr = 32'h0; d_we = 1'b0; d_be = 4'h0; d_wdata = 32'h0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      i_req_valid = 1'b1; i_addr = 32'h8;
      d_req_valid = 1'b1; d_addr = 32'h10; d_we = 1'b1; d_be = 4'hF; d_wdata = 32'hFFFF_FFFF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid} !== 4'b0) begin errors++; $display("FAIL reset_handshake got=%b exp=0000", {i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid}); end
      checks++; if ({mem_en, mem_we} !== 5'b0) begin errors++; $display("FAIL reset_mem_en_we got=%b exp=00000", {mem_en, mem_we}); end
      checks++; if ({mem_addr, mem_wdata} !== 40'b0) begin errors++; $display("FAIL reset_mem_addr_wdata got=%h exp=0", {mem_addr, mem_wdata}); end
      checks++; if ({i_rdata, d_rdata} !== 64'b0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", {i_rdata, d_rdata}); end
      idle_inputs();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b0) begin errors++; $display("FAIL reset_release_rsp got=%b exp=00", {i_rsp_valid, d_rsp_valid}); end
      cyc();
   endtask

   task automatic test_tie();
      logic [7:0] iw, dw;
      iw = 8'($urandom); dw = 8'($urandom);
      i_req_valid = 1'b1; i_addr = {22'b0, iw, 2'b00};
      d_req_valid = 1'b1; d_addr = {22'b0, dw, 2'b10}; d_we = 1'b0;
      @(negedge clk);
      checks++; if ({i_req_ready, d_req_ready} !== 2'b10) begin errors++; $display("FAIL tie1_grant got=%b exp=10", {i_req_ready, d_req_ready}); end
      checks++; if (mem_addr !== iw) begin errors++; $display("FAIL tie1_mem_addr got=%h exp=%h", mem_addr, iw); end
      cyc(); i_req_valid = 1'b0;
      @(negedge clk);
      checks++; if ({i_rsp_valid, d_req_ready} !== 2'b10) begin errors++; $display("FAIL tie1_i_rsp got=%b exp=10", {i_rsp_valid, d_req_ready}); end
      checks++; if (i_rdata !== ref_mem[iw]) begin errors++; $display("FAIL tie1_i_rdata got=%h exp=%h", i_rdata, ref_mem[iw]); end
      cyc();
      @(negedge clk);
      checks++; if ({i_req_ready, d_req_ready} !== 2'b01) begin errors++; $display("FAIL tie1_d_grant got=%b exp=01", {i_req_ready, d_req_ready}); end
      checks++; if (mem_addr !== dw) begin errors++; $display("FAIL tie1_d_mem_addr got=%h exp=%h", mem_addr, dw); end
      cyc(); d_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (d_rdata !== ref_mem[dw] || d_rsp_valid !== 1'b1) begin errors++; $display("FAIL tie1_d_rsp got=%b/%h exp=1/%h", d_rsp_valid, d_rdata, ref_mem[dw]); end
      cyc();
      i_req_valid = 1'b1;
      @(negedge clk);
      checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL tie_i_alone got=%b exp=1", i_req_ready); end
      cyc(); i_req_valid = 1'b0;
      cyc();
      i_req_valid = 1'b1; d_req_valid = 1'b1;
      @(negedge clk);
      checks++; if ({i_req_ready, d_req_ready} !== 2'b01) begin errors++; $display("FAIL tie2_grant got=%b exp=01", {i_req_ready, d_req_ready}); end
      cyc(); d_req_valid = 1'b0;
      @(negedge clk);
      checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b01) begin errors++; $display("FAIL tie2_d_rsp got=%b exp=01", {i_rsp_valid, d_rsp_valid}); end
      cyc();
      @(negedge clk);
      checks++; if ({i_req_ready, d_req_ready} !== 2'b10) begin errors++; $display("FAIL tie2_i_grant got=%b exp=10", {i_req_ready, d_req_ready}); end
      cyc(); i_req_valid = 1'b0;
      cyc();
   endtask

   task automatic test_single_fetch();
      i_req_valid = 1'b1; i_addr = 32'h8;
      @(negedge clk);
      checks++; if ({i_req_ready, mem_en, mem_we} !== 6'b110000) begin errors++; $display("FAIL fetch_accept got=%b exp=110000", {i_req_ready, mem_en, mem_we}); end
      checks++; if (mem_addr !== 8'd2) begin errors++; $display("FAIL fetch_mem_addr got=%h exp=02", mem_addr); end
      cyc(); i_addr = 32'hC;
      @(negedge clk);
      checks++; if ({i_rsp_valid, i_req_ready, mem_en} !== 3'b100) begin errors++; $display("FAIL fetch_resp_cycle got=%b exp=100", {i_rsp_valid, i_req_ready, mem_en}); end
      checks++; if (i_rdata !== ref_mem[2]) begin errors++; $display("FAIL fetch_rdata got=%h exp=%h", i_rdata, ref_mem[2]); end
      cyc();
      @(negedge clk);
      checks++; if (i_req_ready !== 1'b1 || mem_addr !== 8'd3) begin errors++; $display("FAIL fetch_again got=%b/%h exp=1/03", i_req_ready, mem_addr); end
      cyc(); i_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (i_rdata !== ref_mem[3]) begin errors++; $display("FAIL fetch2_rdata got=%h exp=%h", i_rdata, ref_mem[3]); end
      cyc();
   endtask

   task automatic test_store_load();
      d_req_valid = 1'b1; d_addr = 32'h10; d_we = 1'b1; d_be = 4'b0011; d_wdata = 32'hAABBCCDD;
      @(negedge clk);
      checks++; if ({d_req_ready, mem_en, mem_we} !== 6'b110011) begin errors++; $display("FAIL store_accept got=%b exp=110011", {d_req_ready, mem_en, mem_we}); end
      checks++; if (mem_addr !== 8'd4 || mem_wdata !== 32'hAABBCCDD) begin errors++; $display("FAIL store_addr_data got=%h/%h exp=04/aabbccdd", mem_addr, mem_wdata); end
      ref_mem[4] = merge(ref_mem[4], 32'hAABBCCDD, 4'b0011);
      cyc(); d_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (d_rsp_valid !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL store_rsp got=%b/%h exp=1/0", d_rsp_valid, d_rdata); end
      cyc();
      d_req_valid = 1'b1; d_we = 1'b0;
      @(negedge clk);
      checks++; if ({d_req_ready, mem_en, mem_we} !== 6'b110000) begin errors++; $display("FAIL load_accept got=%b exp=110000", {d_req_ready, mem_en, mem_we}); end
      cyc(); d_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (d_rdata !== ref_mem[4]) begin errors++; $display("FAIL load_rdata got=%h exp=%h", d_rdata, ref_mem[4]); end
      checks++; if (d_rdata[15:0] !== 16'hCCDD) begin errors++; $display("FAIL load_low_half got=%h exp=ccdd", d_rdata[15:0]); end
      cyc();
   endtask

   task automatic test_out_of_range();
      logic [31:0] fetch_addrs [3];
      fetch_addrs[0] = 32'(MW * 4); fetch_addrs[1] = 32'h8000_0008; fetch_addrs[2] = 32'(MW * 4 - 4);
      for (int k = 0; k < 3; k++) begin
         i_req_valid = 1'b1; i_addr = fetch_addrs[k];
         @(negedge clk);
         checks++; if ({i_req_ready, mem_en} !== {1'b1, k == 2}) begin errors++; $display("FAIL oor_fetch%0d_accept got=%b exp=1%0d", k, {i_req_ready, mem_en}, k == 2); end
         cyc(); i_req_valid = 1'b0;
         @(negedge clk);
         checks++; if (i_rsp_valid !== 1'b1 || i_rdata !== ((k == 2) ? ref_mem[MW-1] : 32'h0)) begin errors++; $display("FAIL oor_fetch%0d_rsp got=%b/%h exp=1/%h", k, i_rsp_valid, i_rdata, (k == 2) ? ref_mem[MW-1] : 32'h0); end
         cyc();
      end
      d_req_valid = 1'b1; d_addr = 32'(MW * 4); d_we = 1'b1; d_be = 4'hF; d_wdata = ~ref_mem[0];
      @(negedge clk);
      checks++; if ({d_req_ready, mem_en} !== 2'b10) begin errors++; $display("FAIL oor_store_accept got=%b exp=10", {d_req_ready, mem_en}); end
      cyc(); d_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (d_rsp_valid !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL oor_store_rsp got=%b/%h exp=1/0", d_rsp_valid, d_rdata); end
      cyc();
      d_req_valid = 1'b1; d_addr = 32'h0; d_we = 1'b0;
      cyc(); d_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (d_rdata !== ref_mem[0]) begin errors++; $display("FAIL oor_store_dropped got=%h exp=%h", d_rdata, ref_mem[0]); end
      cyc();
   endtask

   task automatic test_back_to_back();
      int n_i, n_d;
      logic exp_ai, exp_ad, exp_ri, exp_rd, prev_ai, prev_ad;
      n_i = 0; n_d = 0; prev_ai = 1'b0; prev_ad = 1'b0;
      i_req_valid = 1'b1; i_addr = 32'd20;
      cyc(); i_req_valid = 1'b0;
      cyc();
      i_req_valid = 1'b1; i_addr = 32'd20;
      d_req_valid = 1'b1; d_addr = 32'd24; d_we = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         exp_ad = (c % 2 == 0) && ((c / 2) % 2 == 0);
         exp_ai = (c % 2 == 0) && ((c / 2) % 2 == 1);
         exp_rd = (c % 2 == 1) && (((c - 1) / 2) % 2 == 0);
         exp_ri = (c % 2 == 1) && (((c - 1) / 2) % 2 == 1);
         checks++; if ({i_req_ready, d_req_ready} !== {exp_ai, exp_ad}) begin errors++; $display("FAIL b2b_c%0d_ready got=%b exp=%b", c, {i_req_ready, d_req_ready}, {exp_ai, exp_ad}); end
         checks++; if ({i_rsp_valid, d_rsp_valid} !== {exp_ri, exp_rd}) begin errors++; $display("FAIL b2b_c%0d_rsp got=%b exp=%b", c, {i_rsp_valid, d_rsp_valid}, {exp_ri, exp_rd}); end
         checks++; if ((i_rsp_valid && !prev_ai) || (d_rsp_valid && !prev_ad)) begin errors++; $display("FAIL b2b_c%0d_unrequested_rsp got=%b exp=%b", c, {i_rsp_valid, d_rsp_valid}, {prev_ai, prev_ad}); end
         if (exp_ri) begin checks++; if (i_rdata !== ref_mem[5]) begin errors++; $display("FAIL b2b_c%0d_i_rdata got=%h exp=%h", c, i_rdata, ref_mem[5]); end end
         if (exp_rd) begin checks++; if (d_rdata !== ref_mem[6]) begin errors++; $display("FAIL b2b_c%0d_d_rdata got=%h exp=%h", c, d_rdata, ref_mem[6]); end end
         n_i += int'(i_rsp_valid); n_d += int'(d_rsp_valid);
         prev_ai = i_req_ready; prev_ad = d_req_ready;
         cyc();
      end
      idle_inputs();
      checks++; if (n_i != 5 || n_d != 5) begin errors++; $display("FAIL b2b_counts got=%0d/%0d exp=5/5", n_i, n_d); end
      cyc();
   endtask

   task automatic test_reset_mid_access();
      i_req_valid = 1'b1; i_addr = 32'd28;
      @(negedge clk);
      checks++; if (i_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_accept got=%b exp=1", i_req_ready); end
      cyc();
      rst_n = 1'b0; d_req_valid = 1'b1; d_addr = 32'd32; d_we = 1'b0;
      @(negedge clk);
      checks++; if ({i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, mem_en, mem_we} !== 9'b0) begin errors++; $display("FAIL midrst_outputs got=%b exp=0", {i_req_ready, d_req_ready, i_rsp_valid, d_rsp_valid, mem_en, mem_we}); end
      checks++; if ({i_rdata, d_rdata, mem_addr, mem_wdata} !== 104'b0) begin errors++; $display("FAIL midrst_data got=%h exp=0", {i_rdata, d_rdata, mem_addr, mem_wdata}); end
      cyc();
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if ({i_rsp_valid, d_rsp_valid} !== 2'b00) begin errors++; $display("FAIL midrst_no_rsp got=%b exp=00", {i_rsp_valid, d_rsp_valid}); end
      checks++; if ({i_req_ready, d_req_ready} !== 2'b10) begin errors++; $display("FAIL midrst_tie got=%b exp=10", {i_req_ready, d_req_ready}); end
      cyc(); i_req_valid = 1'b0;
      @(negedge clk);
      checks++; if (i_rsp_valid !== 1'b1 || i_rdata !== ref_mem[7]) begin errors++; $display("FAIL midrst_i_rsp got=%b/%h exp=1/%h", i_rsp_valid, i_rdata, ref_mem[7]); end
      cyc();
      @(negedge clk);
      checks++; if (d_req_ready !== 1'b1) begin errors++; $display("FAIL midrst_d_grant got=%b exp=1", d_req_ready); end
      cyc(); d_req_valid = 1'b0;
      cyc();
   endtask

   task automatic test_random();
      logic m_busy, m_own_d, m_last_d, win_i, win_d, inr;
      logic [31:0] m_data, sel;
      idle_inputs();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      m_busy = 1'b0; m_own_d = 1'b0; m_last_d = 1'b1; m_data = 32'h0;
      for (int c = 0; c < 400; c++) begin
         if (!i_req_valid && $urandom_range(0, 1) == 1) begin i_req_valid = 1'b1; i_addr = rand_addr(); end
         if (!d_req_valid && $urandom_range(0, 1) == 1) begin
            d_req_valid = 1'b1; d_addr = rand_addr(); d_we = 1'($urandom); d_be = 4'($urandom); d_wdata = $urandom;
         end
         win_i = !m_busy && i_req_valid && (!d_req_valid || m_last_d);
         win_d = !m_busy && d_req_valid && (!i_req_valid || !m_last_d);
         sel   = win_d ? d_addr : i_addr;
         inr   = (sel >> 2) < MW;
         @(negedge clk);
         checks++; if ({i_req_ready, d_req_ready} !== {win_i, win_d}) begin errors++; $display("FAIL rnd_c%0d_ready got=%b exp=%b", c, {i_req_ready, d_req_ready}, {win_i, win_d}); end
         checks++; if (mem_en !== ((win_i || win_d) && inr)) begin errors++; $display("FAIL rnd_c%0d_mem_en got=%b exp=%b", c, mem_en, (win_i || win_d) && inr); end
         if ((win_i || win_d) && inr) begin
            checks++; if (mem_addr !== sel[9:2] || mem_we !== ((win_d && d_we) ? d_be : 4'h0)) begin errors++; $display("FAIL rnd_c%0d_mem_access got=%h/%b exp=%h/%b", c, mem_addr, mem_we, sel[9:2], (win_d && d_we) ? d_be : 4'h0); end
         end
         checks++; if ({i_rsp_valid, d_rsp_valid} !== {m_busy && !m_own_d, m_busy && m_own_d}) begin errors++; $display("FAIL rnd_c%0d_rsp got=%b exp=%b", c, {i_rsp_valid, d_rsp_valid}, {m_busy && !m_own_d, m_busy && m_own_d}); end
         checks++; if (i_rdata !== ((m_busy && !m_own_d) ? m_data : 32'h0) || d_rdata !== ((m_busy && m_own_d) ? m_data : 32'h0)) begin errors++; $display("FAIL rnd_c%0d_rdata got=%h/%h exp_owner_d=%b data=%h", c, i_rdata, d_rdata, m_own_d, m_data); end
         if (win_i || win_d) begin
            m_own_d  = win_d;
            m_data   = (!inr || (win_d && d_we)) ? 32'h0 : ref_mem[sel[9:2]];
            if (win_d && d_we && inr) ref_mem[sel[9:2]] = merge(ref_mem[sel[9:2]], d_wdata, d_be);
            m_last_d = win_d;
            m_busy   = 1'b1;
         end else begin
            m_busy   = 1'b0;
         end
         cyc();
         if (win_i) i_req_valid = 1'b0;
         if (win_d) d_req_valid = 1'b0;
      end
      idle_inputs();
      cyc(); cyc();
   endtask

   initial begin
      logic [31:0] v;
      for (int k = 0; k < MW; k++) begin
         v = $urandom;
         env_mem[k] = v;
         ref_mem[k] = v;
      end
      idle_inputs();
      test_reset();
      test_tie();
      test_single_fetch();
      test_store_load();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_access();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
